// File: rtl/xor_stream_cipher_if.sv
// Valid/ready word stream with an end-of-message marker.
// The master drives valid/data/last and the slave drives ready.
interface xor_stream_cipher_if #(
    parameter int DATA_W = 16
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: a rotating key table schedule with optional ciphertext chaining,
// and one output register with pass-through backpressure.
module xor_stream_cipher #(
    parameter int                DATA_W    = 16,
    parameter int                KEY_DEPTH = 4,
    parameter logic [DATA_W-1:0] IV        = {DATA_W{1'b0}},
    localparam int               AW        = $clog2(KEY_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_wr_en,
    input  logic [AW-1:0]        key_wr_addr,
    input  logic [DATA_W-1:0]    key_wr_data,
    input  logic                 start,
    input  logic                 mode_chain,
    input  logic                 decrypt,
    xor_stream_cipher_if.slave   in_bus,
    xor_stream_cipher_if.master  out_bus,
    output logic                 busy,
    output logic [15:0]          word_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] IDX_ONE = AW'(1'b1);

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] key_r [KEY_DEPTH];
    logic [AW-1:0]     idx_r;
    logic [DATA_W-1:0] chain_r;
    logic              chain_en_r;
    logic              decrypt_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [DATA_W-1:0] out_data_r;
    logic              busy_r;
    logic [15:0]       word_count_r;

    logic              start_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              consume_s;
    logic [DATA_W-1:0] cipher_s;

    // Handshake strobes and the cipher datapath for the word currently offered
    always_comb begin
        start_s    = 1'b0;
        in_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            start_s = start;
        end else begin
            start_s = 1'b0;
        end
        if (state_r == ST_RUN) begin
            in_ready_s = !out_valid_r || out_bus.ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s  = in_bus.valid && in_ready_s;
        consume_s = out_valid_r && out_bus.ready;
        if (chain_en_r) begin
            cipher_s = in_bus.data ^ key_r[idx_r] ^ chain_r;
        end else begin
            cipher_s = in_bus.data ^ key_r[idx_r];
        end
    end

    // Next-state logic for the message sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && in_bus.last) state_s = ST_DRAIN;
                else                         state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (consume_s && out_last_r) state_s = ST_IDLE;
                else                         state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks the state exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Key table; a write alongside start lands before the first word can be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_DEPTH; i++) begin
                key_r[i] <= {DATA_W{1'b0}};
            end
        end else if (key_wr_en && (state_r == ST_IDLE)) begin
            key_r[key_wr_addr] <= key_wr_data;
        end
    end

    // Message context: key index, chain register, mode latches and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r        <= {AW{1'b0}};
            chain_r      <= IV;
            chain_en_r   <= 1'b0;
            decrypt_r    <= 1'b0;
            word_count_r <= 16'h0000;
        end else if (start_s) begin
            idx_r        <= {AW{1'b0}};
            chain_r      <= IV;
            chain_en_r   <= mode_chain;
            decrypt_r    <= decrypt;
            word_count_r <= 16'h0000;
        end else if (accept_s) begin
            idx_r <= idx_r + IDX_ONE;
            if (word_count_r != 16'hFFFF) begin
                word_count_r <= word_count_r + 16'd1;
            end
            // Decrypt chains on the received ciphertext so both directions share one chain value
            if (chain_en_r) begin
                chain_r <= decrypt_r ? in_bus.data : cipher_s;
            end
        end
    end

    // Output register: refilled on accept, emptied on consume when nothing new arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= in_bus.last;
            out_data_r  <= cipher_s;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_bus.ready  = in_ready_s;
    assign out_bus.valid = out_valid_r;
    assign out_bus.data  = out_data_r;
    assign out_bus.last  = out_last_r;
    assign busy          = busy_r;
    assign word_count    = word_count_r;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Scoreboard bench for xor_stream_cipher: stimulus queues hand-computed words,
// a concurrent monitor pops and compares each consumed output.
module tb_xor_stream_cipher;

    localparam int DATA_W    = 16;
    localparam int KEY_DEPTH = 4;
    localparam int AW        = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_wr_en;
    logic [AW-1:0]     key_wr_addr;
    logic [DATA_W-1:0] key_wr_data;
    logic              start;
    logic              mode_chain;
    logic              decrypt;
    logic              busy;
    logic [15:0]       word_count;

    xor_stream_cipher_if #(.DATA_W(DATA_W)) in_bus ();
    xor_stream_cipher_if #(.DATA_W(DATA_W)) out_bus ();

    xor_stream_cipher #(
        .DATA_W   (DATA_W),
        .KEY_DEPTH(KEY_DEPTH),
        .IV       (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_wr_en  (key_wr_en),
        .key_wr_addr(key_wr_addr),
        .key_wr_data(key_wr_data),
        .start      (start),
        .mode_chain (mode_chain),
        .decrypt    (decrypt),
        .in_bus     (in_bus),
        .out_bus    (out_bus),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          tb_done  = 1'b0;
    logic [16:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [16:0] e;
        while (!tb_done) begin
            @(negedge clk);
            if (!rst && out_bus.valid && out_bus.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: actual=%h expected=none", out_bus.data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_bus.data), 32'(e[15:0]));
                    check("out_last", 32'(out_bus.last), 32'(e[16]));
                end
            end
        end
    endtask

    task automatic write_key(input logic [AW-1:0] a, input logic [15:0] d);
        key_wr_en   = 1'b1;
        key_wr_addr = a;
        key_wr_data = d;
        @(posedge clk); #1;
        key_wr_en   = 1'b0;
    endtask

    task automatic start_msg(input logic chain, input logic dec);
        start      = 1'b1;
        mode_chain = chain;
        decrypt    = dec;
        @(posedge clk); #1;
        start      = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("in_ready_after_start", 32'(in_bus.ready), 32'd1);
    endtask

    task automatic send_word(input logic [15:0] d, input logic l, input logic [15:0] exp_d, input bit push);
        int n;
        in_bus.valid = 1'b1;
        in_bus.data  = d;
        in_bus.last  = l;
        if (push) exp_q.push_back({l, exp_d});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_bus.ready && n < 40);
        check("accept_in_time", 32'(in_bus.ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        in_bus.valid = 1'b0;
        in_bus.last  = 1'b0;
    endtask

    task automatic finish_msg();
        int  n;
        bit  seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = out_bus.valid && out_bus.ready && out_bus.last;
        end
        check("last_consumed", 32'(seen), 32'd1);
        @(posedge clk); #1;
        check("busy_after_last", 32'(busy), 32'd0);
    endtask

    task automatic run_tests();
        // Plain mode, two words
        start_msg(1'b0, 1'b0);
        send_word(16'hB309, 1'b0, 16'hA13D, 1'b1);
        send_word(16'hB309, 1'b1, 16'hE571, 1'b1);
        idle_in();
        finish_msg();

        // Key wrap over five words
        start_msg(1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 16'h1234, 1'b1);
        send_word(16'h0000, 1'b0, 16'h5678, 1'b1);
        send_word(16'h0000, 1'b0, 16'h9ABC, 1'b1);
        send_word(16'h0000, 1'b0, 16'hDEF0, 1'b1);
        send_word(16'h0000, 1'b1, 16'h1234, 1'b1);
        idle_in();
        finish_msg();
        check("word_count_wrap", 32'(word_count), 32'd5);

        // Chain encrypt then decrypt
        start_msg(1'b1, 1'b0);
        send_word(16'h0000, 1'b0, 16'h1234, 1'b1);
        send_word(16'h0000, 1'b1, 16'h444C, 1'b1);
        idle_in();
        finish_msg();
        start_msg(1'b1, 1'b1);
        send_word(16'h1234, 1'b0, 16'h0000, 1'b1);
        send_word(16'h444C, 1'b1, 16'h0000, 1'b1);
        idle_in();
        finish_msg();

        // Backpressure: three stalled cycles on the first output
        out_bus.ready = 1'b0;
        start_msg(1'b0, 1'b0);
        fork
            begin
                send_word(16'h0000, 1'b0, 16'h1234, 1'b1);
                send_word(16'h0000, 1'b0, 16'h5678, 1'b1);
                send_word(16'h0000, 1'b0, 16'h9ABC, 1'b1);
                send_word(16'h0000, 1'b1, 16'hDEF0, 1'b1);
                idle_in();
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_bus.valid && n < 40);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stall_in_ready", 32'(in_bus.ready), 32'd0);
                    check("stall_out_data", 32'(out_bus.data), 32'h1234);
                    check("stall_out_valid", 32'(out_bus.valid), 32'd1);
                end
                @(posedge clk); #1;
                out_bus.ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("resume_back_to_back", 32'(out_bus.valid), 32'd1);
                end
            end
        join
        finish_msg();

        // Key write and start during RUN are ignored
        start_msg(1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 16'h1234, 1'b1);
        idle_in();
        key_wr_en   = 1'b1;
        key_wr_addr = 2'd0;
        key_wr_data = 16'hFFFF;
        start       = 1'b1;
        @(posedge clk); #1;
        key_wr_en   = 1'b0;
        start       = 1'b0;
        check("word_count_after_ignored_start", 32'(word_count), 32'd1);
        send_word(16'h0000, 1'b1, 16'h5678, 1'b1);
        idle_in();
        finish_msg();
        check("word_count_two", 32'(word_count), 32'd2);
        start_msg(1'b0, 1'b0);
        send_word(16'h0000, 1'b1, 16'h1234, 1'b1);
        idle_in();
        finish_msg();

        // Reset mid-message with an output word pending
        start_msg(1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 16'h1234, 1'b1);
        send_word(16'h0000, 1'b0, 16'h5678, 1'b1);
        idle_in();
        @(posedge clk); #1;
        out_bus.ready = 1'b0;
        send_word(16'h7777, 1'b0, 16'h0000, 1'b0);
        idle_in();
        check("word_count_before_reset", 32'(word_count), 32'd3);
        check("pending_before_reset", 32'(out_bus.valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_bus.ready = 1'b1;
        check("rst_out_valid", 32'(out_bus.valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_in_ready", 32'(in_bus.ready), 32'd0);
        check("rst_out_data", 32'(out_bus.data), 32'd0);
        start_msg(1'b0, 1'b0);
        send_word(16'hA5A5, 1'b0, 16'hA5A5, 1'b1);
        send_word(16'h3C3C, 1'b0, 16'h3C3C, 1'b1);
        send_word(16'h0F0F, 1'b0, 16'h0F0F, 1'b1);
        send_word(16'hC3D2, 1'b1, 16'hC3D2, 1'b1);
        idle_in();
        finish_msg();

        tb_done = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        key_wr_en     = 1'b0;
        key_wr_addr   = 2'd0;
        key_wr_data   = 16'h0000;
        start         = 1'b0;
        mode_chain    = 1'b0;
        decrypt       = 1'b0;
        in_bus.valid  = 1'b0;
        in_bus.data   = 16'h0000;
        in_bus.last   = 1'b0;
        out_bus.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_in_ready", 32'(in_bus.ready), 32'd0);
        check("reset_out_valid", 32'(out_bus.valid), 32'd0);
        check("reset_out_data", 32'(out_bus.data), 32'd0);
        check("reset_out_last", 32'(out_bus.last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_word_count", 32'(word_count), 32'd0);

        write_key(2'd0, 16'h1234);
        write_key(2'd1, 16'h5678);
        write_key(2'd2, 16'h9ABC);
        write_key(2'd3, 16'hDEF0);

        fork
            monitor_loop();
            run_tests();
        join

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
